// File: rtl/multiply_divide_unit_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package multiply_divide_unit_pkg;

    localparam int MDU_ITERATIONS = 32;
    localparam int CLOCK_PERIOD   = 10;

    typedef enum logic [2:0] {
        MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU,
        MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU
    } mdu_op_t;

    typedef enum logic [1:0] {
        MDU_IDLE, MDU_CALC, MDU_FINISH
    } mdu_state_t;

    function automatic logic op_signed_a(input mdu_op_t op);
        return (op == MDU_MUL) || (op == MDU_MULH) || (op == MDU_MULHSU) ||
               (op == MDU_DIV) || (op == MDU_REM);
    endfunction

    function automatic logic op_signed_b(input mdu_op_t op);
        return (op == MDU_MUL) || (op == MDU_MULH) ||
               (op == MDU_DIV) || (op == MDU_REM);
    endfunction

endpackage

// File: rtl/multiply_divide_unit_division_step.sv
// One restoring-division step: shift the next dividend bit in, subtract if it fits.
module division_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN:0] trial;

    // Partial remainder is always below the divisor, so one extra bit covers the shifted value.
    assign trial   = {rem_in, quo_in[XLEN-1]} - {1'b0, divisor};
    assign rem_out = trial[XLEN] ? {rem_in[XLEN-2:0], quo_in[XLEN-1]} : trial[XLEN-1:0];
    assign quo_out = {quo_in[XLEN-2:0], ~trial[XLEN]};

endmodule

// File: rtl/multiply_divide_unit.sv
// Iterative RV32M multiply/divide: magnitude shift-add or restoring divide over
// 32 cycles, sign correction in FINISH, registered Result with a one-cycle Done.
module multiply_divide_unit
    import multiply_divide_unit_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int COUNT_WIDTH = 6
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            MDU_Start,
    input  logic [2:0]      MDU_Control,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic            Flush,
    output logic [XLEN-1:0] Result,
    output logic            MDU_Busy,
    output logic            MDU_Done
);

    mdu_state_t state, state_next;
    mdu_op_t    op_in, op_q;

    logic [COUNT_WIDTH-1:0] counter;
    logic [XLEN-1:0]        src_a_q, abs_a, abs_b;
    logic                   sign_a, sign_b, sign_a_q, sign_b_q;
    logic                   zero_in, overflow_in, div_zero_q, overflow_q;
    logic                   accept, last_step, finish_ok;
    logic [2*XLEN-1:0]      product, mcand, product_signed;
    logic [XLEN-1:0]        mplier, rem, quo, divisor, rem_next, quo_next;
    logic [XLEN-1:0]        quo_signed, rem_signed, result_next;

    assign op_in       = mdu_op_t'(MDU_Control);
    assign sign_a      = op_signed_a(op_in) & SrcA[XLEN-1];
    assign sign_b      = op_signed_b(op_in) & SrcB[XLEN-1];
    assign abs_a       = sign_a ? -SrcA : SrcA;
    assign abs_b       = sign_b ? -SrcB : SrcB;
    assign zero_in     = (SrcB == '0);
    assign overflow_in = ((op_in == MDU_DIV) || (op_in == MDU_REM)) &&
                         (SrcA == {1'b1, {(XLEN-1){1'b0}}}) && (SrcB == '1);

    assign accept    = (state == MDU_IDLE) && MDU_Start && !Flush;
    assign last_step = (counter == COUNT_WIDTH'(MDU_ITERATIONS - 1));
    assign finish_ok = (state == MDU_FINISH) && !Flush;
    assign MDU_Busy  = (state != MDU_IDLE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= MDU_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            MDU_IDLE:   if (accept)
                            state_next = (op_in[2] && (zero_in || overflow_in)) ? MDU_FINISH : MDU_CALC;
            MDU_CALC:   if (Flush)          state_next = MDU_IDLE;
                        else if (last_step) state_next = MDU_FINISH;
            MDU_FINISH: state_next = MDU_IDLE;
            default:    state_next = MDU_IDLE;
        endcase
    end

    division_step #(.XLEN(XLEN)) u_division_step (
        .rem_in  (rem),
        .quo_in  (quo),
        .divisor (divisor),
        .rem_out (rem_next),
        .quo_out (quo_next)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            op_q       <= MDU_MUL;
            counter    <= '0;
            src_a_q    <= '0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            div_zero_q <= 1'b0;
            overflow_q <= 1'b0;
            product    <= '0;
            mcand      <= '0;
            mplier     <= '0;
            rem        <= '0;
            quo        <= '0;
            divisor    <= '0;
        end else if (accept) begin
            op_q       <= op_in;
            counter    <= '0;
            src_a_q    <= SrcA;
            sign_a_q   <= sign_a;
            sign_b_q   <= sign_b;
            div_zero_q <= zero_in;
            overflow_q <= overflow_in;
            product    <= '0;
            mcand      <= {{XLEN{1'b0}}, abs_a};
            mplier     <= abs_b;
            rem        <= '0;
            quo        <= abs_a;
            divisor    <= abs_b;
        end else if (state == MDU_CALC) begin
            counter <= counter + 1'b1;
            if (op_q[2]) begin
                rem <= rem_next;
                quo <= quo_next;
            end else begin
                if (mplier[0]) product <= product + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
            end
        end
    end

    // Magnitudes are computed unsigned; signs are reapplied only here.
    assign product_signed = (sign_a_q ^ sign_b_q) ? -product : product;
    assign quo_signed     = (sign_a_q ^ sign_b_q) ? -quo : quo;
    assign rem_signed     = sign_a_q ? -rem : rem;

    always_comb begin
        result_next = '0;
        case (op_q)
            MDU_MUL:                        result_next = product_signed[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: result_next = product_signed[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:
                if (div_zero_q)      result_next = '1;
                else if (overflow_q) result_next = {1'b1, {(XLEN-1){1'b0}}};
                else                 result_next = quo_signed;
            MDU_REM, MDU_REMU:
                if (div_zero_q)      result_next = src_a_q;
                else if (overflow_q) result_next = '0;
                else                 result_next = rem_signed;
            default:                        result_next = '0;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Result   <= '0;
            MDU_Done <= 1'b0;
        end else begin
            MDU_Done <= finish_ok;
            if (finish_ok) Result <= result_next;
        end
    end

endmodule

// File: tb/tb_multiply_divide_unit.sv
// Directed self-checking bench for multiply_divide_unit: vector table plus
// hand-written flush, reset and back-to-back sequences.
module tb_multiply_divide_unit;
    import multiply_divide_unit_pkg::*;

    logic        CLK, RST, MDU_Start, Flush, MDU_Busy, MDU_Done;
    logic [2:0]  MDU_Control;
    logic [31:0] SrcA, SrcB, Result;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        mdu_op_t     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_result;
        int          exp_done;
    } vec_t;

    vec_t vecs[13];

    multiply_divide_unit #(.XLEN(32), .COUNT_WIDTH(6)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .MDU_Start   (MDU_Start),
        .MDU_Control (MDU_Control),
        .SrcA        (SrcA),
        .SrcB        (SrcB),
        .Flush       (Flush),
        .Result      (Result),
        .MDU_Busy    (MDU_Busy),
        .MDU_Done    (MDU_Done)
    );

    initial CLK = 1'b0;
    always #(CLOCK_PERIOD/2) CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          done_cyc = -1;
        logic        busy_ok  = 1'b1;
        logic [31:0] res      = '0;
        MDU_Control = v.op;
        SrcA        = v.a;
        SrcB        = v.b;
        MDU_Start   = 1'b1;
        for (int c = 1; c <= 60 && done_cyc < 0; c++) begin
            next_cycle();
            if (c == 1) begin
                MDU_Start   = 1'b0;
                SrcA        = $urandom;
                SrcB        = $urandom;
                MDU_Control = 3'($urandom_range(7));
            end
            if (MDU_Done) begin
                done_cyc = c;
                res      = Result;
                if (MDU_Busy) busy_ok = 1'b0;
            end else if (!MDU_Busy) begin
                busy_ok = 1'b0;
            end
        end
        check($sformatf("vec%0d done_cycle", idx), 32'(done_cyc), 32'(v.exp_done));
        check($sformatf("vec%0d result", idx), res, v.exp_result);
        check($sformatf("vec%0d busy_window", idx), 32'(busy_ok), 32'd1);
        next_cycle();
        check($sformatf("vec%0d done_one_cycle", idx), 32'(MDU_Done), 32'd0);
    endtask

    initial begin
        int          n_done;
        logic        res_kept;
        logic [31:0] last_exp;

        vecs[0]  = '{MDU_MUL,    32'd7,        32'd6,        32'h0000002A, 34};
        vecs[1]  = '{MDU_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34};
        vecs[2]  = '{MDU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34};
        vecs[3]  = '{MDU_MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 34};
        vecs[4]  = '{MDU_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 34};
        vecs[5]  = '{MDU_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 34};
        vecs[6]  = '{MDU_DIVU,   32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, 34};
        vecs[7]  = '{MDU_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 2};
        vecs[8]  = '{MDU_REM,    32'd5,        32'd0,        32'h00000005, 2};
        vecs[9]  = '{MDU_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2};
        vecs[10] = '{MDU_MUL,    32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 34};
        vecs[11] = '{MDU_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34};
        vecs[12] = '{MDU_REMU,   32'd100,      32'd7,        32'h00000002, 34};

        RST = 1'b1; MDU_Start = 1'b0; Flush = 1'b0;
        MDU_Control = '0; SrcA = '0; SrcB = '0;
        #1;
        check("reset Result", Result, 32'h0);
        check("reset Busy", 32'(MDU_Busy), 32'd0);
        check("reset Done", 32'(MDU_Done), 32'd0);
        next_cycle();
        next_cycle();
        RST = 1'b0;
        next_cycle();

        for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);
        last_exp = vecs[12].exp_result;

        // Flush mid-multiply, with a simultaneous Start that must be dropped.
        MDU_Control = MDU_MUL; SrcA = 32'd3; SrcB = 32'd3; MDU_Start = 1'b1;
        n_done = 0; res_kept = 1'b1;
        for (int c = 1; c <= 48; c++) begin
            next_cycle();
            if (c == 10) check("flush busy_before", 32'(MDU_Busy), 32'd1);
            if (c == 11) check("flush busy_after", 32'(MDU_Busy), 32'd0);
            if (c == 12) check("flush dropped_start", 32'(MDU_Busy), 32'd0);
            if (c <= 45 && MDU_Done) n_done++;
            if (c >= 11 && c <= 45 && Result !== last_exp) res_kept = 1'b0;
            if (c == 46) begin
                check("flush restart done", 32'(MDU_Done), 32'd1);
                check("flush restart result", Result, 32'd9);
            end
            case (c)
                1:  MDU_Start = 1'b0;
                10: begin Flush = 1'b1; MDU_Start = 1'b1; SrcA = 32'd5; SrcB = 32'd5; end
                11: begin Flush = 1'b0; MDU_Start = 1'b0; end
                12: begin MDU_Start = 1'b1; SrcA = 32'd3; SrcB = 32'd3; MDU_Control = MDU_MUL; end
                13: MDU_Start = 1'b0;
                default: ;
            endcase
        end
        check("flush no_done", 32'(n_done), 32'd0);
        check("flush result_kept", 32'(res_kept), 32'd1);

        // Asynchronous reset in the middle of a divide.
        MDU_Control = MDU_DIV; SrcA = 32'd100; SrcB = 32'd7; MDU_Start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
            MDU_Start = 1'b0;
        end
        #2 RST = 1'b1;
        #1;
        check("async_rst Busy", 32'(MDU_Busy), 32'd0);
        check("async_rst Done", 32'(MDU_Done), 32'd0);
        check("async_rst Result", Result, 32'h0);
        next_cycle();
        RST = 1'b0;
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            next_cycle();
            if (MDU_Done || MDU_Busy) n_done++;
        end
        check("async_rst stays_idle", 32'(n_done), 32'd0);

        // Start held through busy with changing operands, then accepted in the Done cycle.
        MDU_Control = MDU_MUL; SrcA = 32'd7; SrcB = 32'd6; MDU_Start = 1'b1;
        n_done = 0;
        for (int c = 1; c <= 70; c++) begin
            next_cycle();
            if (MDU_Done) n_done++;
            if (c == 34) begin
                check("held_start done34", 32'(MDU_Done), 32'd1);
                check("held_start result34", Result, 32'h2A);
            end
            if (c == 35) check("b2b busy35", 32'(MDU_Busy), 32'd1);
            if (c == 68) begin
                check("b2b done68", 32'(MDU_Done), 32'd1);
                check("b2b result68", Result, 32'd4);
            end
            if (c == 1)  begin SrcA = 32'd2; SrcB = 32'd2; end
            if (c == 34) MDU_Start = 1'b1;
            if (c == 35) MDU_Start = 1'b0;
        end
        check("held_start done_count", 32'(n_done), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
